// File: rtl/mult_div_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// Funct codes, bus widths, FSM state encoding and an abs helper.
package mult_div_pkg;

    localparam int DATA_W  = 32;
    localparam int DBL_W   = 64;
    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1a;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    function automatic logic [DATA_W-1:0] abs32(
        input logic [DATA_W-1:0] x,
        input logic              sgn
    );
        return (sgn && x[DATA_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// EX <-> multiply/divide unit bundle.
// master = EX stage, slave = mult_div.
interface mult_div_if;
    import mult_div_pkg::*;

    logic [FUNCT_W-1:0] funct;
    logic [DATA_W-1:0]  operand_1;
    logic [DATA_W-1:0]  operand_2;
    logic               done;
    logic [DBL_W-1:0]   result;

    modport master (
        output funct, operand_1, operand_2,
        input  done, result
    );

    modport slave (
        input  funct, operand_1, operand_2,
        output done, result
    );

endinterface

// File: rtl/mult_div_div_core.sv
// One restoring unsigned division step.
// Accumulator holds {remainder, quotient}; one quotient bit per call.
module mult_div_div_core
    import mult_div_pkg::*;
(
    input  logic [DBL_W-1:0]  acc_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DBL_W-1:0]  acc_out
);

    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] diff;

    assign rem_sh = acc_in[DBL_W-1:DATA_W-1];
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        if (!diff[DATA_W]) begin
            acc_out = {diff[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b1};
        end else begin
            acc_out = {acc_in[DBL_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; result = {hi, lo}.
// MULT_DIV_FAST_MULT_EN: single-cycle combinational multiply, divide unchanged.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     halt,
    mult_div_if.slave bus
);

    localparam int CNT_W = $clog2(ITER);

    state_e             state;
    logic [CNT_W-1:0]   counter;
    logic [DBL_W-1:0]   acc;
    logic [DBL_W-1:0]   acc_nxt;
    logic [DBL_W-1:0]   acc_div;
    logic [DBL_W-1:0]   fixed;
    logic [DBL_W-1:0]   result_q;
    logic [DATA_W-1:0]  mcand;
    logic [DATA_W-1:0]  divisor;
    logic [DATA_W-1:0]  a_abs;
    logic [DATA_W-1:0]  b_abs;
    logic [DATA_W:0]    mul_sum;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               done_q;
    logic               start;
    logic               dec_div;
    logic               dec_sgn;

    always_comb begin
        start   = 1'b0;
        dec_div = 1'b0;
        dec_sgn = 1'b0;
        unique case (1'b1)
            bus.funct == FUNCT_MULT: begin
                start   = 1'b1;
                dec_sgn = 1'b1;
            end
            bus.funct == FUNCT_MULTU: begin
                start   = 1'b1;
            end
            bus.funct == FUNCT_DIV: begin
                start   = 1'b1;
                dec_div = 1'b1;
                dec_sgn = 1'b1;
            end
            bus.funct == FUNCT_DIVU: begin
                start   = 1'b1;
                dec_div = 1'b1;
            end
            default: ;
        endcase
    end

    assign a_abs = abs32(bus.operand_1, dec_sgn);
    assign b_abs = abs32(bus.operand_2, dec_sgn);

`ifdef MULT_DIV_FAST_MULT_EN
    logic [DBL_W-1:0] ext_1;
    logic [DBL_W-1:0] ext_2;
    logic [DBL_W-1:0] fast_prod;

    assign ext_1 = {{DATA_W{dec_sgn & bus.operand_1[DATA_W-1]}},
                    bus.operand_1};
    assign ext_2 = {{DATA_W{dec_sgn & bus.operand_2[DATA_W-1]}},
                    bus.operand_2};
    assign fast_prod = ext_1 * ext_2;
`endif

    // Shift-add: hi half accumulates, multiplier drains out of lo half
    assign mul_sum = {1'b0, acc[DBL_W-1:DATA_W]}
                   + (acc[0] ? {1'b0, mcand} : '0);

    mult_div_div_core u_div_core (
        .acc_in  (acc),
        .divisor (divisor),
        .acc_out (acc_div)
    );

    assign acc_nxt = op_div ? acc_div : {mul_sum, acc[DATA_W-1:1]};

    always_comb begin
        fixed = acc_nxt;
        if (op_div) begin
            if (neg_res) fixed[DATA_W-1:0] = -acc_nxt[DATA_W-1:0];
            if (neg_rem) fixed[DBL_W-1:DATA_W] = -acc_nxt[DBL_W-1:DATA_W];
        end else if (neg_res) begin
            fixed = -acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            counter  <= '0;
            acc      <= '0;
            mcand    <= '0;
            divisor  <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (flush) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand   <= a_abs;
                        divisor <= b_abs;
                        acc     <= {{DATA_W{1'b0}},
                                    dec_div ? a_abs : b_abs};
                        op_div  <= dec_div;
                        neg_res <= dec_sgn &
                                   (bus.operand_1[DATA_W-1] ^
                                    bus.operand_2[DATA_W-1]);
                        neg_rem <= dec_sgn & bus.operand_1[DATA_W-1];
                        counter <= '0;
                        state   <= ST_CALC;
`ifdef MULT_DIV_FAST_MULT_EN
                        if (!dec_div) begin
                            result_q <= fast_prod;
                            done_q   <= 1'b1;
                            state    <= ST_DONE;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    acc     <= acc_nxt;
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(ITER - 1)) begin
                        result_q <= fixed;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!halt) begin
                        done_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: driver pushes expected results,
// a negedge monitor pops and compares on each new done.
module tb_mult_div;
    import mult_div_pkg::*;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MLAT     = 1;
    localparam int MLAT_B2B = 2;
`else
    localparam int MLAT     = 33;
    localparam int MLAT_B2B = 34;
`endif
    localparam int DLAT     = 33;
    localparam int DLAT_B2B = 34;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic halt  = 1'b0;

    mult_div_if bus();

    mult_div dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .halt  (halt),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_done = 1'b0;
    logic        prev_halt = 1'b0;
    logic [63:0] last_res = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (!prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    chk(name_q.pop_front(), bus.result, exp_q.pop_front());
                end
                last_res = bus.result;
            end else begin
                chk("done_twice_no_halt", {63'd0, prev_halt}, 64'd1);
                chk("held_result", bus.result, last_res);
            end
        end
        prev_done = bus.done & !rst;
        prev_halt = halt;
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Called just after a negedge; returns just after the done negedge
    task automatic run_op(string nm, logic [5:0] f, logic [31:0] a,
                          logic [31:0] b, logic [63:0] exp, int lat,
                          int hold);
        int cnt;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.done && cnt < 200);
        chk({nm, "_latency"}, 64'(cnt), 64'(lat));
        repeat (hold) begin
            @(negedge clk);
            chk({nm, "_halt_done"}, {63'd0, bus.done}, 64'd1);
        end
        #1;
        halt      = 1'b0;
        bus.funct = 6'h00;
    endtask

    task automatic watch_no_done(string nm, int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk(nm, 64'(seen), 64'd0);
        #1;
    endtask

    initial begin
        bus.funct     = 6'h00;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_result", bus.result, 64'd0);
        #1;
        rst = 1'b0;
        idle(2);

        run_op("mult_neg", FUNCT_MULT, 32'hFFFFFFFE, 32'h3,
               64'hFFFFFFFF_FFFFFFFA, MLAT, 0);
        idle(1);
        run_op("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001, MLAT, 0);
        idle(1);
        run_op("mult_min", FUNCT_MULT, 32'h80000000, 32'h80000000,
               64'h40000000_00000000, MLAT, 0);
        idle(1);
        run_op("multu_shift", FUNCT_MULTU, 32'h12345678, 32'h10,
               64'h00000001_23456780, MLAT, 0);
        idle(1);
        run_op("div_neg7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'h2,
               64'hFFFFFFFF_FFFFFFFD, DLAT, 0);
        idle(1);
        run_op("div_wrap", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF,
               64'h00000000_80000000, DLAT, 0);
        idle(1);
        run_op("div_7_neg2", FUNCT_DIV, 32'h7, 32'hFFFFFFFE,
               64'h00000001_FFFFFFFD, DLAT, 0);
        idle(1);
        run_op("divu_by0", FUNCT_DIVU, 32'h7, 32'h0,
               64'h00000007_FFFFFFFF, DLAT, 0);
        idle(1);
        run_op("div_neg_by0", FUNCT_DIV, 32'hFFFFFFF9, 32'h0,
               64'hFFFFFFF9_00000001, DLAT, 0);

        idle(1);
        run_op("b2b_divu", FUNCT_DIVU, 32'd100, 32'd7,
               64'h00000002_0000000E, DLAT, 0);
        run_op("b2b_multu", FUNCT_MULTU, 32'd5, 32'd6,
               64'h00000000_0000001E, MLAT_B2B, 0);
        idle(1);
        run_op("b2b_div_a", FUNCT_DIV, 32'd20, 32'd3,
               64'h00000002_00000006, DLAT, 0);
        run_op("b2b_div_b", FUNCT_DIVU, 32'd9, 32'd4,
               64'h00000001_00000002, DLAT_B2B, 0);

        idle(1);
        halt = 1'b1;
        run_op("mult_halt", FUNCT_MULT, 32'd3, 32'hFFFFFFFC,
               64'hFFFFFFFF_FFFFFFF4, MLAT, 3);
        watch_no_done("after_halt_no_done", 3);

        bus.funct     = FUNCT_DIV;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd3;
        idle(10);
        flush     = 1'b1;
        bus.funct = 6'h00;
        idle(1);
        flush = 1'b0;
        watch_no_done("flush_no_done", 40);
        chk("flush_result_kept", bus.result, 64'hFFFFFFFF_FFFFFFF4);

        bus.funct     = FUNCT_DIVU;
        bus.operand_1 = 32'd50;
        bus.operand_2 = 32'd5;
        idle(5);
        rst       = 1'b1;
        bus.funct = 6'h00;
        @(negedge clk);
        chk("rst_mid_done", {63'd0, bus.done}, 64'd0);
        chk("rst_mid_result", bus.result, 64'd0);
        #1;
        rst = 1'b0;
        watch_no_done("rst_no_done", 40);

        idle(1);
        run_op("after_rst_div", FUNCT_DIVU, 32'd50, 32'd5,
               64'h00000000_0000000A, DLAT, 0);
        idle(2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
